// File: rtl/datapath_pkg.sv
// Shared definitions for the multiplier datapath: operation codes and the
// control-state encoding of the shift register.
package datapath_pkg;

  localparam logic [2:0] OP_HOLD  = 3'd0;
  localparam logic [2:0] OP_LOAD  = 3'd1;
  localparam logic [2:0] OP_SHL   = 3'd2;
  localparam logic [2:0] OP_SHR   = 3'd3;
  localparam logic [2:0] OP_SAR   = 3'd4;
  localparam logic [2:0] OP_ROL   = 3'd5;
  localparam logic [2:0] OP_ROR   = 3'd6;
  localparam logic [2:0] OP_CLEAR = 3'd7;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/shift_counter.sv
// Loadable down-counter that tracks the remaining single-bit shifts;
// last flags the final step.
module shift_counter #(
  parameter int AMT_W = 3
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             load,
  input  logic             dec,
  input  logic [AMT_W-1:0] load_val,
  output logic             last
);

  logic [AMT_W-1:0] count;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - AMT_W'(1);
    end
  end

  assign last = (count == AMT_W'(1));

endmodule

// File: rtl/shift_register_n.sv
// N-bit storage/shift element with start/busy/done handshake; shifts and
// rotates advance one bit per clock under control of a down-counter.
module shift_register_n
  import datapath_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int AMT_W = 3
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [AMT_W-1:0] amt,
  input  logic [WIDTH-1:0] d,
  input  logic             sin,
  output logic [WIDTH-1:0] q,
  output logic             sout,
  output logic             busy,
  output logic             done,
  output logic             zero
);

  // Handshake: start (with op/amt/d) is taken only on an edge where busy=0;
  // busy stays high across a multi-cycle shift and done pulses for exactly
  // one cycle after the edge that completes any accepted operation.

  state_t           state, state_nxt;
  logic [2:0]       op_r;
  logic [WIDTH-1:0] q_nxt;
  logic             sout_nxt, done_nxt;
  logic             cnt_load, cnt_dec, cnt_last;
  logic             is_shift_op, long_op;

  assign is_shift_op = (op >= OP_SHL) && (op <= OP_ROR);
  assign long_op     = is_shift_op && (amt != '0);

  shift_counter #(.AMT_W(AMT_W)) u_cnt (
    .clk      (clk),
    .clr      (clr),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .load_val (amt),
    .last     (cnt_last)
  );

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start && long_op) state_nxt = ST_SHIFT;
      ST_SHIFT: if (cnt_last)         state_nxt = ST_IDLE;
      default:                        state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    q_nxt    = q;
    sout_nxt = sout;
    done_nxt = 1'b0;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          // A zero-count shift completes like a single-edge op.
          done_nxt = !long_op;
          cnt_load = long_op;
          if (op == OP_LOAD) begin
            q_nxt    = d;
            sout_nxt = 1'b0;
          end else if (op == OP_CLEAR) begin
            q_nxt    = '0;
            sout_nxt = 1'b0;
          end
        end
      end
      ST_SHIFT: begin
        cnt_dec  = 1'b1;
        done_nxt = cnt_last;
        case (op_r)
          OP_SHL: begin q_nxt = {q[WIDTH-2:0], sin};      sout_nxt = q[WIDTH-1]; end
          OP_SHR: begin q_nxt = {sin, q[WIDTH-1:1]};      sout_nxt = q[0];       end
          OP_SAR: begin q_nxt = {q[WIDTH-1], q[WIDTH-1:1]}; sout_nxt = q[0];     end
          OP_ROL: begin q_nxt = {q[WIDTH-2:0], q[WIDTH-1]}; sout_nxt = q[WIDTH-1]; end
          OP_ROR: begin q_nxt = {q[0], q[WIDTH-1:1]};     sout_nxt = q[0];       end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      q    <= '0;
      sout <= 1'b0;
      done <= 1'b0;
      op_r <= OP_HOLD;
    end else begin
      q    <= q_nxt;
      sout <= sout_nxt;
      done <= done_nxt;
      if (cnt_load) op_r <= op;
    end
  end

  assign busy = (state == ST_SHIFT);
  assign zero = (q == '0);

endmodule

// File: tb/tb_shift_register_n.sv
// Randomized bench for shift_register_n against an arithmetic reference of
// the shift/rotate rules and the start/busy/done timing.
module tb_shift_register_n;

  logic       clk, clr, start, sin;
  logic [2:0] op, amt;
  logic [7:0] d, q;
  logic       sout, busy, done, zero;

  int         n_checks = 0;
  int         n_pass   = 0;
  logic [7:0] m_q      = 8'h00;
  logic       m_sout   = 1'b0;

  shift_register_n #(.WIDTH(8), .AMT_W(3)) dut (
    .clk(clk), .clr(clr), .start(start), .op(op), .amt(amt), .d(d),
    .sin(sin), .q(q), .sout(sout), .busy(busy), .done(done), .zero(zero)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Reference: one bit step expressed with plain arithmetic; returns {sout, q}.
  function automatic logic [8:0] model_step(input int o, input int qv, input int s);
    int nq, so;
    nq = qv;
    so = 0;
    case (o)
      2: begin nq = (qv * 2 + s) % 256;           so = qv / 128; end
      3: begin nq = qv / 2 + s * 128;             so = qv % 2;   end
      4: begin nq = qv / 2 + (qv / 128) * 128;    so = qv % 2;   end
      5: begin nq = (qv * 2) % 256 + qv / 128;    so = qv / 128; end
      6: begin nq = qv / 2 + (qv % 2) * 128;      so = qv % 2;   end
      default: ;
    endcase
    return {so[0], nq[7:0]};
  endfunction

  // Drives one operation and follows it to its done edge, comparing every cycle.
  task automatic exercise_op(input string name, input logic [2:0] o, input logic [2:0] n,
                             input logic [7:0] dv, input bit rand_sin, input bit noise,
                             input bit b2b);
    bit         long_op;
    bit         s;
    logic [8:0] r;
    if (!b2b) @(negedge clk);
    start = 1'b1; op = o; amt = n; d = dv; sin = 1'($urandom_range(0, 1));
    long_op = (o >= 3'd2) && (o <= 3'd6) && (n != 3'd0);
    if (o == 3'd1) begin m_q = dv; m_sout = 1'b0; end
    else if (o == 3'd7) begin m_q = 8'h00; m_sout = 1'b0; end
    @(negedge clk);
    // While busy, a competing LOAD request must have no effect.
    start = noise; op = 3'd1; d = 8'hFF; amt = 3'($urandom_range(0, 7));
    if (!long_op) begin
      start = 1'b0;
      n_checks++;
      if ({q, sout, busy, done, zero} !== {m_q, m_sout, 1'b0, 1'b1, (m_q == 8'h00)})
        $display("FAIL %s accept: q=%h sout=%b busy=%b done=%b zero=%b, expected q=%h sout=%b busy=0 done=1 zero=%b",
                 name, q, sout, busy, done, zero, m_q, m_sout, (m_q == 8'h00));
      else n_pass++;
    end else begin
      n_checks++;
      if ({q, sout, busy, done, zero} !== {m_q, m_sout, 1'b1, 1'b0, (m_q == 8'h00)})
        $display("FAIL %s accept: q=%h sout=%b busy=%b done=%b zero=%b, expected q=%h sout=%b busy=1 done=0 zero=%b",
                 name, q, sout, busy, done, zero, m_q, m_sout, (m_q == 8'h00));
      else n_pass++;
      for (int i = 1; i <= int'(n); i++) begin
        s = rand_sin ? 1'($urandom_range(0, 1)) : 1'b0;
        sin = s;
        @(negedge clk);
        r = model_step(int'(o), int'(m_q), int'(s));
        m_q = r[7:0];
        m_sout = r[8];
        n_checks++;
        if ({q, sout, busy, done, zero} !== {m_q, m_sout, (i < int'(n)), (i == int'(n)), (m_q == 8'h00)})
          $display("FAIL %s shift %0d: q=%h sout=%b busy=%b done=%b zero=%b, expected q=%h sout=%b busy=%b done=%b",
                   name, i, q, sout, busy, done, zero, m_q, m_sout, (i < int'(n)), (i == int'(n)));
        else n_pass++;
      end
      start = 1'b0;
    end
  endtask

  task automatic test_reset();
    #1;
    n_checks++;
    if ({q, sout, busy, done, zero} !== 12'b0000_0000_0001)
      $display("FAIL reset_initial: q=%h sout=%b busy=%b done=%b zero=%b, expected q=00 sout=0 busy=0 done=0 zero=1",
               q, sout, busy, done, zero);
    else n_pass++;
    repeat (2) @(negedge clk);
    clr = 1'b1;
    exercise_op("reset_load", 3'd1, 3'd0, 8'($urandom), 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    start = 1'b1; op = 3'd2; amt = 3'd7; d = 8'($urandom);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #2 clr = 1'b0;
    m_q = 8'h00; m_sout = 1'b0;
    #1;
    n_checks++;
    if ({q, sout, busy, done, zero} !== 12'b0000_0000_0001)
      $display("FAIL reset_midop: q=%h sout=%b busy=%b done=%b zero=%b, expected q=00 sout=0 busy=0 done=0 zero=1",
               q, sout, busy, done, zero);
    else n_pass++;
    @(negedge clk);
    clr = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_checks++;
      if ({q, busy, done} !== 10'h000)
        $display("FAIL reset_after: q=%h busy=%b done=%b, expected q=00 busy=0 done=0", q, busy, done);
      else n_pass++;
    end
  endtask

  task automatic test_load_clear();
    exercise_op("load", 3'd1, 3'd0, 8'hA5, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    n_checks++;
    if ({q, busy, done, zero} !== {8'hA5, 3'b000})
      $display("FAIL load_after: q=%h busy=%b done=%b zero=%b, expected q=a5 busy=0 done=0 zero=0", q, busy, done, zero);
    else n_pass++;
    exercise_op("clear", 3'd7, 3'd0, 8'h5A, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    n_checks++;
    if ({q, sout, done, zero} !== {8'h00, 3'b001})
      $display("FAIL clear_after: q=%h sout=%b done=%b zero=%b, expected q=00 sout=0 done=0 zero=1", q, sout, done, zero);
    else n_pass++;
  endtask

  task automatic test_shl();
    exercise_op("shl_load", 3'd1, 3'd0, 8'hA5, 1'b0, 1'b0, 1'b0);
    exercise_op("shl3", 3'd2, 3'd3, 8'h00, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if ({q, sout} !== {8'h28, 1'b1})
      $display("FAIL shl3_final: q=%h sout=%b, expected q=28 sout=1", q, sout);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({busy, done} !== 2'b00)
      $display("FAIL shl3_done_width: busy=%b done=%b, expected busy=0 done=0", busy, done);
    else n_pass++;
  endtask

  task automatic test_sar_ror();
    exercise_op("sar_load", 3'd1, 3'd0, 8'h80, 1'b0, 1'b0, 1'b0);
    exercise_op("sar2", 3'd4, 3'd2, 8'h00, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if ({q, sout} !== {8'hE0, 1'b0})
      $display("FAIL sar2_final: q=%h sout=%b, expected q=e0 sout=0", q, sout);
    else n_pass++;
    exercise_op("ror_load", 3'd1, 3'd0, 8'h01, 1'b0, 1'b0, 1'b0);
    exercise_op("ror1", 3'd6, 3'd1, 8'h00, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if ({q, sout} !== {8'h80, 1'b1})
      $display("FAIL ror1_final: q=%h sout=%b, expected q=80 sout=1", q, sout);
    else n_pass++;
  endtask

  task automatic test_busy_abort();
    bit         s;
    logic [8:0] r;
    exercise_op("abort_load", 3'd1, 3'd0, 8'($urandom_range(1, 255)), 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    start = 1'b1; op = 3'd2; amt = 3'd5; d = 8'h00;
    @(negedge clk);
    start = 1'b1; op = 3'd1; d = 8'hFF;
    for (int i = 1; i <= 2; i++) begin
      s = 1'($urandom_range(0, 1));
      sin = s;
      @(negedge clk);
      r = model_step(2, int'(m_q), int'(s));
      m_q = r[7:0]; m_sout = r[8];
      n_checks++;
      if ({q, sout, busy, done} !== {m_q, m_sout, 2'b10})
        $display("FAIL abort_shift %0d: q=%h sout=%b busy=%b done=%b, expected q=%h sout=%b busy=1 done=0",
                 i, q, sout, busy, done, m_q, m_sout);
      else n_pass++;
    end
    start = 1'b0;
    #2 clr = 1'b0;
    m_q = 8'h00; m_sout = 1'b0;
    #1;
    n_checks++;
    if ({q, sout, busy, done, zero} !== 12'b0000_0000_0001)
      $display("FAIL abort_clr: q=%h sout=%b busy=%b done=%b zero=%b, expected q=00 sout=0 busy=0 done=0 zero=1",
               q, sout, busy, done, zero);
    else n_pass++;
    @(negedge clk);
    clr = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if ({q, busy, done} !== 10'h000)
        $display("FAIL abort_quiet: q=%h busy=%b done=%b, expected q=00 busy=0 done=0", q, busy, done);
      else n_pass++;
    end
    exercise_op("abort_reload", 3'd1, 3'd0, 8'h3C, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (q !== 8'h3C)
      $display("FAIL abort_reload_q: q=%h, expected q=3c", q);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    exercise_op("rol0", 3'd5, 3'd0, 8'h00, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (q !== 8'h3C)
      $display("FAIL rol0_q: q=%h, expected q=3c", q);
    else n_pass++;
    exercise_op("rol1_b2b", 3'd5, 3'd1, 8'h00, 1'b1, 1'b0, 1'b1);
    n_checks++;
    if (q !== 8'h78)
      $display("FAIL rol1_b2b_q: q=%h, expected q=78", q);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int k = 0; k < 40; k++) begin
      exercise_op("random", 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                  8'($urandom), 1'b1, 1'($urandom_range(0, 1)), 1'b0);
      if ($urandom_range(0, 1) == 1) begin
        @(negedge clk);
        n_checks++;
        if ({q, busy, done} !== {m_q, 2'b00})
          $display("FAIL random_idle: q=%h busy=%b done=%b, expected q=%h busy=0 done=0", q, busy, done, m_q);
        else n_pass++;
      end
    end
  endtask

  initial begin
    clr = 1'b0; start = 1'b0; op = 3'd0; amt = 3'd0; d = 8'h00; sin = 1'b0;
    test_reset();
    test_load_clear();
    test_shl();
    test_sar_ror();
    test_busy_abort();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
